// File: rtl/diffuse_pkg.sv
// Shared state encoding, scent/timer constants and lookup helpers for the diffuser scheduler.
package diffuse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME  = 3'd1,
    SPRAY  = 3'd2,
    REST   = 3'd3,
    MANUAL = 3'd4,
    PURGE  = 3'd5
  } state_t;

  localparam logic [1:0] COTTON = 2'd0;
  localparam logic [1:0] WOODY  = 2'd1;
  localparam logic [1:0] CITRUS = 2'd2;

  localparam logic [6:0] T30  = 7'd30;
  localparam logic [6:0] T60  = 7'd60;
  localparam logic [6:0] T120 = 7'd120;

  // Unused code 3 falls back to Cotton.
  function automatic logic [2:0] scent_onehot(input logic [1:0] s);
    case (s)
      COTTON:  return 3'b001;
      WOODY:   return 3'b010;
      CITRUS:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [6:0] timer_minutes(input logic [1:0] t);
    case (t)
      2'd1:    return T60;
      2'd2:    return T120;
      default: return T30;
    endcase
  endfunction

endpackage

// File: rtl/diffuse_scheduler_if.sv
// Bus between the mode controller, the scheduler and the pump/valve/LCD consumers.
interface diffuse_scheduler_if;
  import diffuse_pkg::*;

  logic [1:0] scent_sel;
  logic [1:0] timer_sel;
  logic       pump_on;
  logic       pump_off;
  logic       manual_on;
  logic       pump_en;
  logic [2:0] valve_sel;
  logic [6:0] remaining_min;
  logic       busy;
  logic       done;
  state_t     state_o;

  modport master (
    output scent_sel, timer_sel, pump_on, pump_off, manual_on,
    input  pump_en, valve_sel, remaining_min, busy, done, state_o
  );

  modport slave (
    input  scent_sel, timer_sel, pump_on, pump_off, manual_on,
    output pump_en, valve_sel, remaining_min, busy, done, state_o
  );

endinterface

// File: rtl/diffuse_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1, tick is high while the count sits at its last value.
module diffuse_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/diffuse_scheduler.sv
// Pump/valve sequencer for timed PRIME/SPRAY/REST sessions and manual bursts.
// Define DIFF_PURGE_EN to add a pump-only PURGE phase after natural session expiry.
module diffuse_scheduler
  import diffuse_pkg::*;
#(
  parameter int TICK_DIV    = 1_000_000,
  parameter int SEC_PER_MIN = 60,
  parameter int PRIME_S     = 2,
  parameter int SPRAY_S     = 10,
  parameter int REST_S      = 50,
  parameter int MANUAL_S    = 5,
  parameter int PURGE_S     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  diffuse_scheduler_if.slave   bus
);

  localparam logic [15:0] MIN_LAST = 16'(SEC_PER_MIN - 1);

  state_t      state, next_state;
  logic [1:0]  scent_q, scent_nxt;
  logic [6:0]  rem_q;
  logic [15:0] sec_cnt, min_cnt;
  logic        pump_q, busy_q, done_q, done_nxt;
  logic [2:0]  valve_q;
  logic        tick, entering, in_session, phase_done, min_tick, expire;
  logic        session_start, manual_start;

  function automatic logic [15:0] phase_len(input state_t s);
    case (s)
      PRIME:   return 16'(PRIME_S);
      SPRAY:   return 16'(SPRAY_S);
      REST:    return 16'(REST_S);
      MANUAL:  return 16'(MANUAL_S);
      PURGE:   return 16'(PURGE_S);
      default: return 16'd0;
    endcase
  endfunction

  diffuse_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   ((state == IDLE) || entering),
    .tick  (tick)
  );

  assign entering   = (next_state != state);
  assign in_session = (state == PRIME) || (state == SPRAY) || (state == REST);
  assign phase_done = tick && ((sec_cnt + 16'd1) == phase_len(state));
  assign min_tick   = in_session && tick && (min_cnt == MIN_LAST);
  assign expire     = min_tick && (rem_q == 7'd1);

  always_comb begin
    next_state    = state;
    session_start = 1'b0;
    manual_start  = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pump_on && !bus.pump_off) begin
          next_state    = PRIME;
          session_start = 1'b1;
        end else if (bus.manual_on && !bus.pump_off) begin
          next_state   = MANUAL;
          manual_start = 1'b1;
        end
      end
      PRIME:  if (phase_done) next_state = SPRAY;
      SPRAY:  if (phase_done) next_state = REST;
      REST:   if (phase_done) next_state = SPRAY;
      MANUAL: if (phase_done) next_state = IDLE;
`ifdef DIFF_PURGE_EN
      PURGE: begin
        if (phase_done) begin
          next_state = IDLE;
          done_nxt   = 1'b1;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
    // Session expiry overrides whatever phase boundary happens on the same tick.
    if (expire) begin
`ifdef DIFF_PURGE_EN
      next_state = PURGE;
`else
      next_state = IDLE;
      done_nxt   = 1'b1;
`endif
    end
    if (state != IDLE && bus.pump_off) begin
      next_state = IDLE;
      done_nxt   = 1'b0;
    end
    scent_nxt = scent_q;
    if (session_start || manual_start || (state == REST && next_state == SPRAY))
      scent_nxt = bus.scent_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      scent_q <= COTTON;
      rem_q   <= 7'd0;
      sec_cnt <= 16'd0;
      min_cnt <= 16'd0;
      pump_q  <= 1'b0;
      valve_q <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      scent_q <= scent_nxt;
      if (entering)  sec_cnt <= 16'd0;
      else if (tick) sec_cnt <= sec_cnt + 16'd1;
      if (session_start)         min_cnt <= 16'd0;
      else if (in_session && tick) min_cnt <= (min_cnt == MIN_LAST) ? 16'd0 : min_cnt + 16'd1;
      if (next_state == IDLE)    rem_q <= 7'd0;
      else if (session_start)    rem_q <= timer_minutes(bus.timer_sel);
      else if (min_tick)         rem_q <= rem_q - 7'd1;
      // Outputs are decoded from the state being entered so they align with state_o.
      pump_q  <= (next_state == SPRAY) || (next_state == MANUAL) || (next_state == PURGE);
      valve_q <= ((next_state == PRIME) || (next_state == SPRAY) || (next_state == REST) ||
                  (next_state == MANUAL)) ? scent_onehot(scent_nxt) : 3'b000;
      busy_q  <= (next_state != IDLE);
      done_q  <= done_nxt;
    end
  end

  assign bus.pump_en       = pump_q;
  assign bus.valve_sel     = valve_q;
  assign bus.remaining_min = rem_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.state_o       = state;

endmodule

// File: tb/tb_diffuse_scheduler.sv
// Directed, table-driven bench for diffuse_scheduler with shortened timing parameters.
module tb_diffuse_scheduler;
  import diffuse_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  diffuse_scheduler_if bus();

  diffuse_scheduler #(
    .TICK_DIV(4), .SEC_PER_MIN(2), .PRIME_S(1), .SPRAY_S(2),
    .REST_S(3), .MANUAL_S(2), .PURGE_S(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] scent;
    logic [1:0] timer;
    logic       on;
    logic       off;
    logic       man;
    int         cyc;
    int         st;
    int         pump;
    int         valve;
    int         rem;
    int         busy;
    int         done;
  } vec_t;

  vec_t vecs[19];
  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int inv_bad = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) done_seen++;
      if (bus.pump_en && bus.valve_sel == 3'b000 && bus.state_o != PURGE) inv_bad++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int pump, input int valve,
                           input int rem, input int busy, input int done);
    chk({tag, "_state"}, int'(bus.state_o), st);
    chk({tag, "_pump"},  int'(bus.pump_en), pump);
    chk({tag, "_valve"}, int'(bus.valve_sel), valve);
    chk({tag, "_rem"},   int'(bus.remaining_min), rem);
    chk({tag, "_busy"},  int'(bus.busy), busy);
    chk({tag, "_done"},  int'(bus.done), done);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           scent timer on off man cyc  st pump valve rem busy done
    vecs[0]  = '{2'd2, 2'd0, 1, 0, 0,  1,  1, 0, 4, 30, 1, 0};
    vecs[1]  = '{2'd2, 2'd0, 0, 0, 0,  3,  1, 0, 4, 30, 1, 0};
    vecs[2]  = '{2'd2, 2'd0, 0, 0, 0,  1,  2, 1, 4, 30, 1, 0};
    vecs[3]  = '{2'd2, 2'd0, 0, 0, 0,  3,  2, 1, 4, 30, 1, 0};
    vecs[4]  = '{2'd2, 2'd0, 0, 0, 0,  1,  2, 1, 4, 29, 1, 0};
    vecs[5]  = '{2'd2, 2'd0, 0, 0, 0,  4,  3, 0, 4, 29, 1, 0};
    vecs[6]  = '{2'd2, 2'd0, 0, 0, 0, 12,  2, 1, 4, 27, 1, 0};
    vecs[7]  = '{2'd2, 2'd0, 0, 0, 1,  1,  2, 1, 4, 27, 1, 0};
    vecs[8]  = '{2'd2, 2'd0, 1, 0, 0,  1,  2, 1, 4, 27, 1, 0};
    vecs[9]  = '{2'd2, 2'd0, 1, 1, 0,  1,  0, 0, 0,  0, 0, 0};
    vecs[10] = '{2'd2, 2'd0, 0, 0, 0,  8,  0, 0, 0,  0, 0, 0};
    vecs[11] = '{2'd3, 2'd0, 0, 0, 1,  1,  4, 1, 1,  0, 1, 0};
    vecs[12] = '{2'd3, 2'd0, 0, 0, 0,  7,  4, 1, 1,  0, 1, 0};
    vecs[13] = '{2'd3, 2'd0, 0, 0, 0,  1,  0, 0, 0,  0, 0, 0};
    vecs[14] = '{2'd0, 2'd1, 1, 0, 1,  1,  1, 0, 1, 60, 1, 0};
    vecs[15] = '{2'd0, 2'd1, 0, 0, 0, 12,  3, 0, 1, 59, 1, 0};
    vecs[16] = '{2'd1, 2'd1, 0, 0, 0, 11,  3, 0, 1, 58, 1, 0};
    vecs[17] = '{2'd1, 2'd1, 0, 0, 0,  1,  2, 1, 2, 57, 1, 0};
    vecs[18] = '{2'd1, 2'd1, 0, 1, 0,  1,  0, 0, 0,  0, 0, 0};

    // Reset held while every command input is pulsed.
    bus.scent_sel = 2'd2;
    bus.timer_sel = 2'd2;
    bus.pump_on   = 1'b1;
    bus.pump_off  = 1'b1;
    bus.manual_on = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check_all($sformatf("rst%0d", r), 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    reset         = 1'b0;
    bus.pump_on   = 1'b0;
    bus.pump_off  = 1'b0;
    bus.manual_on = 1'b0;
    step();
    check_all("post_rst", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      bus.scent_sel = vecs[i].scent;
      bus.timer_sel = vecs[i].timer;
      bus.pump_on   = vecs[i].on;
      bus.pump_off  = vecs[i].off;
      bus.manual_on = vecs[i].man;
      for (int c = 0; c < vecs[i].cyc; c++) begin
        step();
        bus.pump_on   = 1'b0;
        bus.pump_off  = 1'b0;
        bus.manual_on = 1'b0;
      end
      check_all($sformatf("v%0d", i), vecs[i].st, vecs[i].pump, vecs[i].valve,
                vecs[i].rem, vecs[i].busy, vecs[i].done);
    end

    // Full 30-minute session (timer code 3 falls back to 30) run to natural expiry.
    bus.scent_sel = 2'd1;
    bus.timer_sel = 2'd3;
    bus.pump_on   = 1'b1;
    step();
    bus.pump_on = 1'b0;
    check_all("exp_start", 1, 0, 2, 30, 1, 0);
    repeat (239) step();
    check_all("exp_last", 3, 0, 2, 1, 1, 0);
    step();
`ifdef DIFF_PURGE_EN
    check_all("purge_in", 5, 1, 0, 0, 1, 0);
    repeat (3) step();
    check_all("purge_end", 5, 1, 0, 0, 1, 0);
    step();
    check_all("purge_idle", 0, 0, 0, 0, 0, 1);
`else
    check_all("exp_idle", 0, 0, 0, 0, 0, 1);
`endif
    step();
    check_all("exp_after", 0, 0, 0, 0, 0, 0);

    chk("done_pulses", done_seen, 1);
    chk("pump_without_valve", inv_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
